dp_sequencer: RTL
=================

Name: dp_sequencer

Overview:
- Command initiator for the 32-bit datapath (register file + 32-bit ALU): drives ALUControl, addr1, addr2, addr3 and wr, and samples Result, Zero and Overflow.
- Accepts 10-bit micro-instructions over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one instruction per clock, retires it by capturing the datapath flags, and keeps issue and overflow statistics.
- Optionally halts on an ALU overflow.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
STOP_ON_OVF, 1, 1 = enter HALT after retiring an instruction with Overflow=1
CNT_W, 16, width of issue_count

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
run  in  1  1 = issuing enabled
in_valid  in  1  instruction offered
in_instr  in  10  {alu[9:7], a1[6:5], a2[4:3], a3[2:1], we[0]}
in_ready  out  1  FIFO can accept
clr_halt  in  1  leave HALT
ALUControl  out  3  to datapath
addr1  out  2  source A register
addr2  out  2  source B register
addr3  out  2  destination register
wr  out  1  register-file write enable
Result  in  32  datapath result
Zero  in  1  datapath flag
Overflow  in  1  datapath flag
last_result  out  32  Result captured at last retire
last_zero  out  1  Zero captured at last retire
last_ovf  out  1  Overflow captured at last retire
busy  out  1  FIFO non-empty or issue in progress
halted  out  1  state == HALT
issue_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
ovf_count  out  8  retires with Overflow=1, saturates at 255

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO flushed; state IDLE.
  - All outputs 0, except in_ready, which is 1 after reset.
  - A reset mid-issue drops the instruction: wr falls to 0 immediately and no retire occurs.
- Push: on a clk edge with in_valid && in_ready, in_instr is written at the tail.
  - in_ready = !full. A pop in the same cycle does not raise in_ready.
  - in_valid while in_ready=0: ignored, no state change.
- FSM states:
  - IDLE: go to ISSUE when run && !empty.
  - ISSUE: the FIFO head is presented combinationally: ALUControl=alu, addr1=a1, addr2=a2, addr3=a3, wr=we.
  - At the clk edge ending an ISSUE cycle the head retires:
    - pop the head;
    - last_result<=Result, last_zero<=Zero, last_ovf<=Overflow;
    - issue_count+1; ovf_count+1 (saturating) if Overflow.
  - Next state after a retire:
    - HALT if STOP_ON_OVF && Overflow;
    - else ISSUE if run && FIFO still non-empty after the pop (a same-edge push counts);
    - else IDLE.
  - HALT: wr=0 and the FIFO is held; pushes are still accepted. On clr_halt=1 go to IDLE.
  - Outside ISSUE, ALUControl, addr* and wr are 0.
- Datapath write: an instruction with we=1 commits in the register file on the same edge it retires. The write is not suppressed by Overflow.
- Latency: an instruction pushed at edge N can be issued at the earliest in the cycle after edge N, and retires at edge N+1.
- Throughput: back-to-back issue, one instruction per cycle. There is no read-after-write hazard, because the write lands at the retire edge before the next read.
- run deasserted during ISSUE: the current instruction still retires; the FSM then goes to IDLE.
- busy = !empty || state==ISSUE.

Test Plan:
- Reset with rst=0 mid-stream → all outputs 0, in_ready=1, issue_count=0. After rst=1 and run=1, nothing issues until a push.
- Push {000,01,10,00,1} with run=1, bench drives Result=0x0000_0007 → the next cycle shows ALUControl=000, addr1=1, addr2=2, addr3=0, wr=1. After that edge: last_result=0x7, issue_count=1, busy=0.
- Push DEPTH+1=5 instructions with run=0 → in_ready=0 after the 4th push and the 5th is ignored. Set run=1 → exactly 4 consecutive ISSUE cycles; issue_count=4.
- With STOP_ON_OVF=1, queue 3 instructions, Overflow=1 on the 2nd → halted=1 after the 2nd retire, ovf_count=1, issue_count=2, wr=0 while halted. Pulse clr_halt → the 3rd retires; issue_count=3.
- Simultaneous push and pop with the FIFO holding 1 entry → continuous issue with no IDLE bubble; order preserved (addr3 sequence 0,1).
- Assert rst=0 during an ISSUE cycle with wr=1 → wr drops to 0 immediately, issue_count stays 0, FIFO empty after release.

Source files
------------

// File: rtl/dp_sequencer.sv
// dp_sequencer: command initiator for a 32-bit register-file + ALU datapath.
// Micro-instructions {alu[9:7], a1[6:5], a2[4:3], a3[2:1], we[0]} arrive over
// a valid/ready handshake into a small FIFO. One instruction is issued per
// ISSUE cycle and retires on the clock edge that ends that cycle. At that edge
// the datapath flags are captured and the statistics are updated.
//
// Ports:
//   clk, rst (async active-low)      clock / reset
//   run                              enables issuing
//   in_valid, in_instr, in_ready     instruction push handshake
//   clr_halt                         leaves HALT
//   ALUControl, addr1..3, wr         command to the datapath (valid in ISSUE only)
//   Result, Zero, Overflow           datapath response, sampled at retire
//   last_result/last_zero/last_ovf   response captured at the last retire
//   busy, halted                     status
//   issue_count, ovf_count           retire statistics
module dp_sequencer #(
  parameter int DEPTH       = 4,
  parameter bit STOP_ON_OVF = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             in_valid,
  input  logic [9:0]       in_instr,
  output logic             in_ready,
  input  logic             clr_halt,
  output logic [2:0]       ALUControl,
  output logic [1:0]       addr1,
  output logic [1:0]       addr2,
  output logic [1:0]       addr3,
  output logic             wr,
  input  logic [31:0]      Result,
  input  logic             Zero,
  input  logic             Overflow,
  output logic [31:0]      last_result,
  output logic             last_zero,
  output logic             last_ovf,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] issue_count,
  output logic [7:0]       ovf_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

  state_t        state, state_next;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, empty, full;
  logic [9:0]    head;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  // Every ISSUE cycle retires the head; ISSUE is only entered with a non-empty FIFO.
  assign pop      = (state == ISSUE);
  assign head     = mem[rd_ptr];

  // Occupancy after this edge; a same-edge push lets issue continue without a bubble.
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign busy   = !empty || (state == ISSUE);
  assign halted = (state == HALT);

  // Storage has no reset: contents are only observed through the head when count > 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_result <= '0;
      last_zero   <= 1'b0;
      last_ovf    <= 1'b0;
      issue_count <= '0;
      ovf_count   <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        last_result <= Result;
        last_zero   <= Zero;
        last_ovf    <= Overflow;
        issue_count <= issue_count + 1'b1;
        if (Overflow && (ovf_count != 8'hFF)) ovf_count <= ovf_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    ALUControl = 3'd0;
    addr1      = 2'd0;
    addr2      = 2'd0;
    addr3      = 2'd0;
    wr         = 1'b0;
    case (state)
      IDLE: begin
        if (run && (count_next != '0)) state_next = ISSUE;
      end
      ISSUE: begin
        ALUControl = head[9:7];
        addr1      = head[6:5];
        addr2      = head[4:3];
        addr3      = head[2:1];
        wr         = head[0];
        if (STOP_ON_OVF && Overflow)          state_next = HALT;
        else if (run && (count_next != '0))   state_next = ISSUE;
        else                                  state_next = IDLE;
      end
      HALT: begin
        if (clr_halt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
